// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive blocks:
// frame-sequencer states and the PARITY parameter encoding.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: accepts one word per valid/ready handshake and serialises it
// as start, LSB-first data, optional parity and stop bits on a registered line.
//
// state | meaning
// IDLE  | line high, data_in_rdy high, waiting for a word
// START | start bit (low) for one bit time
// DATA  | data bits LSB-first, one bit time each
// PAR   | parity bit for one bit time (only when PARITY != PAR_NONE)
// STOP  | line high for STOP_BITS bit times, then back to IDLE
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_in_val,
  output logic                 data_in_rdy,
  output logic                 tx,
  output logic                 busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic              ODD_INV   = (PARITY == PAR_ODD);

  if (CLKS_PER_BIT < 2) begin : g_chk_cpb
    $error("uart_tx: CLKS_PER_BIT must be 2 or more");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_db
    $error("uart_tx: DATA_BITS must be 5 to 9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_chk_par
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_sb
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  uart_state_t          r_state;
  logic [BAUD_W-1:0]    r_baud;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_rdy;

  logic w_baud_last;
  logic w_accept;

  assign w_baud_last = (r_baud == BAUD_LAST);
  assign w_accept    = data_in_val && r_rdy;

  assign tx          = r_tx;
  assign busy        = r_busy;
  assign data_in_rdy = r_rdy;

  // r_idx counts data bits in DATA and stop bits in STOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_rdy   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE || w_baud_last) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + BAUD_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_accept) begin
            r_state <= ST_START;
            r_shift <= data_in;
            r_par   <= (^data_in) ^ ODD_INV;
            r_idx   <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_rdy   <= 1'b0;
          end else begin
            r_busy <= 1'b0;
            r_rdy  <= 1'b1;
          end
        end
        ST_START: begin
          if (w_baud_last) begin
            r_state <= ST_DATA;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_idx   <= '0;
          end
        end
        ST_DATA: begin
          if (w_baud_last) begin
            if (r_idx == DATA_LAST) begin
              r_idx <= '0;
              if (PARITY != PAR_NONE) begin
                r_state <= ST_PAR;
                r_tx    <= r_par;
              end else begin
                r_state <= ST_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end
        end
        ST_PAR: begin
          if (w_baud_last) begin
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
            r_idx   <= '0;
          end
        end
        ST_STOP: begin
          r_tx <= 1'b1;
          if (w_baud_last) begin
            if (r_idx == STOP_LAST) begin
              r_state <= ST_IDLE;
              r_idx   <= '0;
              r_busy  <= 1'b0;
              r_rdy   <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_rdy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations driven by handshake tasks; a per-unit
// monitor compares every serial-line cycle against a frame model from a scoreboard.
module tb_uart_tx;

  localparam int CPB = 4;

  typedef struct {
    int u;
    int data;
    int hs;
    int ncheck;
  } item_t;

  logic            clk = 1'b0;
  logic [3:0]      rst_v;
  logic [3:0]      val_v;
  logic [3:0][8:0] din_v;
  logic [3:0]      rdy_v, tx_v, busy_v;
  logic rdy0, rdy1, rdy2, rdy3;
  logic tx0, tx1, tx2, tx3;
  logic busy0, busy1, busy2, busy3;

  assign rdy_v  = {rdy3, rdy2, rdy1, rdy0};
  assign tx_v   = {tx3, tx2, tx1, tx0};
  assign busy_v = {busy3, busy2, busy1, busy0};

  int edge_cnt = 0;
  int n_chk = 0;
  int n_fail = 0;
  int pushed[4];
  int popped[4];
  int last_hs[4];
  item_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .reset(rst_v[0]), .data_in(din_v[0][7:0]), .data_in_val(val_v[0]),
    .data_in_rdy(rdy0), .tx(tx0), .busy(busy0));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .reset(rst_v[1]), .data_in(din_v[1][7:0]), .data_in_val(val_v[1]),
    .data_in_rdy(rdy1), .tx(tx1), .busy(busy1));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .reset(rst_v[2]), .data_in(din_v[2][7:0]), .data_in_val(val_v[2]),
    .data_in_rdy(rdy2), .tx(tx2), .busy(busy2));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .reset(rst_v[3]), .data_in(din_v[3][6:0]), .data_in_val(val_v[3]),
    .data_in_rdy(rdy3), .tx(tx3), .busy(busy3));

  function automatic int db_of(input int u);
    return (u == 3) ? 7 : 8;
  endfunction
  function automatic int par_of(input int u);
    return (u == 1) ? 1 : (u == 2) ? 2 : 0;
  endfunction
  function automatic int sb_of(input int u);
    return (u == 3) ? 2 : 1;
  endfunction
  function automatic int frame_len(input int u);
    return 1 + db_of(u) + ((par_of(u) != 0) ? 1 : 0) + sb_of(u);
  endfunction

  // Reference frame: start 0, data LSB-first, optional parity, then stop 1s.
  function automatic logic frame_bit(input int u, input int d, input int idx);
    int ones;
    ones = 0;
    if (idx == 0) return 1'b0;
    if (idx <= db_of(u)) return d[idx-1];
    if (par_of(u) != 0 && idx == db_of(u) + 1) begin
      for (int i = 0; i < db_of(u); i++) ones += d[i];
      return (par_of(u) == 1) ? logic'(ones % 2) : logic'(1 - ones % 2);
    end
    return 1'b1;
  endfunction

  task automatic chk(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s unit%0d t=%0t: got %0h expected %0h", name, u, $time, act, exp);
    end
  endtask

  task automatic idle_chk(input int u);
    chk("idle_tx", u, tx_v[u], 1);
    chk("idle_busy", u, busy_v[u], 0);
  endtask

  // Must be called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input int u, input int d, input int ncheck, input bit noisy);
    item_t it;
    int n;
    n = 0;
    din_v[u] = 9'(d);
    val_v[u] = 1'b1;
    while (!rdy_v[u] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_v[u]) begin
      chk("rdy_timeout", u, 0, 1);
      val_v[u] = 1'b0;
      return;
    end
    it.u = u; it.data = d; it.hs = edge_cnt + 1; it.ncheck = ncheck;
    sb_q.push_back(it);
    pushed[u]++;
    last_hs[u] = it.hs;
    @(negedge clk);
    val_v[u] = 1'b0;
    if (noisy) begin
      n = 0;
      while (!rdy_v[u] && n < 500) begin
        val_v[u] = 1'($urandom_range(0, 1));
        din_v[u] = 9'($urandom_range(0, 511));
        @(negedge clk);
        n++;
      end
      val_v[u] = 1'b0;
    end
  endtask

  task automatic wait_done(input int u);
    int n;
    n = 0;
    while (popped[u] != pushed[u] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done", u, popped[u], pushed[u]);
  endtask

  task automatic monitor(input int u);
    item_t it;
    int idx, f, n;
    forever begin
      @(negedge clk);
      idx = -1;
      for (int i = 0; i < sb_q.size(); i++)
        if (idx < 0 && sb_q[i].u == u) idx = i;
      if (idx >= 0) begin
        it = sb_q[idx];
        sb_q.delete(idx);
        while (edge_cnt < it.hs) @(negedge clk);
        chk("mon_align", u, edge_cnt, it.hs);
        f = frame_len(u) * CPB;
        n = (it.ncheck < 0) ? f : it.ncheck;
        for (int k = 0; k < n; k++) begin
          if (k > 0) @(negedge clk);
          chk("tx_bit", u, tx_v[u], frame_bit(u, it.data, k / CPB));
          chk("busy_frame", u, busy_v[u], 1);
          chk("rdy_frame", u, rdy_v[u], 0);
        end
        if (it.ncheck < 0) begin
          @(negedge clk);
          chk("after_tx", u, tx_v[u], 1);
          chk("after_busy", u, busy_v[u], 0);
          chk("after_rdy", u, rdy_v[u], 1);
        end
        popped[u]++;
      end
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_mon
    initial monitor(g);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h1, h2, hs, d;
    for (int u = 0; u < 4; u++) begin
      pushed[u] = 0; popped[u] = 0; last_hs[u] = 0;
    end
    rst_v = 4'hF;
    val_v = 4'h0;
    din_v = '0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      idle_chk(u);
      chk("rst_rdy", u, rdy_v[u], 0);
    end
    rst_v = 4'h0;
    @(negedge clk);
    for (int u = 0; u < 4; u++) chk("rdy_after_rst", u, rdy_v[u], 1);
    repeat (3) begin
      @(negedge clk);
      for (int u = 0; u < 4; u++) idle_chk(u);
    end

    // Reset wins over a same-cycle handshake.
    din_v[0] = 9'h0AA;
    val_v[0] = 1'b1;
    rst_v[0] = 1'b1;
    @(negedge clk);
    idle_chk(0);
    chk("rst_hs_rdy", 0, rdy_v[0], 0);
    rst_v[0] = 1'b0;
    val_v[0] = 1'b0;
    @(negedge clk);
    chk("rst_hs_rdy_back", 0, rdy_v[0], 1);
    idle_chk(0);

    send(0, 'hA5, -1, 0);
    wait_done(0);

    send(0, 'h00, -1, 0);
    h1 = last_hs[0];
    send(0, 'hFF, -1, 0);
    h2 = last_hs[0];
    chk("frame_period", 0, h2 - h1, 41);
    wait_done(0);

    send(1, 'h07, -1, 0);
    wait_done(1);
    send(2, 'h07, -1, 0);
    wait_done(2);
    send(3, 'h55, -1, 0);
    wait_done(3);

    // Abort in data bit 3: samples 16..19 of the frame carry d[3].
    send(0, 'h3C, 17, 0);
    hs = last_hs[0];
    while (edge_cnt < hs + 16) @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk);
    idle_chk(0);
    chk("abort_rdy", 0, rdy_v[0], 0);
    rst_v[0] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      idle_chk(0);
      chk("abort_rdy_back", 0, rdy_v[0], 1);
    end
    wait_done(0);
    send(0, 'hC3, -1, 0);
    wait_done(0);

    for (int u = 0; u < 4; u++) begin
      for (int n = 0; n < 6; n++) begin
        d = int'($urandom_range(0, 511));
        send(u, d, -1, (n % 2) == 1);
        if ($urandom_range(0, 1) == 1) begin
          wait_done(u);
          repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            idle_chk(u);
          end
        end
      end
      wait_done(u);
    end

    repeat (3) @(negedge clk);
    for (int u = 0; u < 4; u++) chk("scoreboard_drained", u, popped[u], pushed[u]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
